// File: rtl/board_grid_renderer.sv
// Renders NUM_P playfields with frame ring, grid, cell colours and a row-clear blink.
// rgb is registered 3 pclk after the counter sample. No backpressure; counters pause while !(hen&&ven).
module board_grid_renderer #(
  parameter int NUM_P        = 2,
  parameter int COLS         = 10,
  parameter int ROWS         = 20,
  parameter int CELL         = 20,
  parameter int H_ACT        = 800,
  parameter int V_ACT        = 600,
  parameter int X0           = 160,
  parameter int Y0           = 160,
  parameter int PITCH        = 280,
  parameter int BLINK_FRAMES = 8,
  parameter int FLASH_FRAMES = 48,
  parameter int AW           = 8
) (
  input  logic                pclk,
  input  logic                rstn,
  input  logic                hen,
  input  logic                ven,
  output logic [NUM_P*AW-1:0] raddr,
  input  logic [NUM_P*3-1:0]  rdata,
  input  logic [NUM_P-1:0]    flash_go,
  input  logic [NUM_P*5-1:0]  flash_row,
  output logic [NUM_P-1:0]    flash_busy,
  output logic [NUM_P-1:0]    flash_done,
  output logic [11:0]         rgb
);
  localparam int XW   = $clog2(H_ACT);
  localparam int YW   = $clog2(V_ACT);
  localparam int RW   = $clog2(CELL);
  localparam int FW   = $clog2(FLASH_FRAMES + 1);
  localparam int BW   = $clog2(BLINK_FRAMES + 1);
  localparam int BWPX = COLS * CELL;
  localparam int BHPX = ROWS * CELL;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fstate_t;

  logic [XW-1:0] x, x_nxt;
  logic [YW-1:0] y, y_nxt;
  logic          adv, x_last, y_last, frame_end;
  logic [7:0]    cy;
  logic [RW-1:0] yr;
  int            xi, yi;

  logic [NUM_P-1:0]    cell_c, ring_c, grid_c, fl_c;
  logic [NUM_P*AW-1:0] raddr_c;
  logic                act1, act2;
  logic [NUM_P-1:0]    cell1, ring1, grid1, fl1, cell2, ring2, grid2, fl2;
  logic [11:0]         rgb_c;

  assign adv       = hen & ven;
  assign x_last    = (x == XW'(H_ACT - 1));
  assign y_last    = (y == YW'(V_ACT - 1));
  assign frame_end = adv & x_last & y_last;
  assign x_nxt     = x_last ? '0 : x + XW'(1);
  assign y_nxt     = y_last ? '0 : y + YW'(1);
  assign xi        = int'(x);
  assign yi        = int'(y);

  // Row/pixel-in-cell counters restart on entering the board's top edge.
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      x  <= '0;
      y  <= '0;
      cy <= '0;
      yr <= '0;
    end else if (adv) begin
      x <= x_nxt;
      if (x_last) begin
        y <= y_nxt;
        if (y_nxt == YW'(Y0)) begin
          cy <= '0;
          yr <= '0;
        end else if (yr == RW'(CELL - 1)) begin
          cy <= cy + 8'd1;
          yr <= '0;
        end else begin
          yr <= yr + RW'(1);
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_P; p++) begin : g_pl
    localparam int BX = X0 + p * PITCH;
    logic [7:0]    cx;
    logic [RW-1:0] xr;
    fstate_t       st, st_n;
    logic [4:0]    row_q, row_n;
    logic [FW-1:0] fc, fc_n;
    logic [BW-1:0] bc, bc_n;
    logic          ph, ph_n;

    always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
        cx <= '0;
        xr <= '0;
      end else if (adv) begin
        if (x_nxt == XW'(BX)) begin
          cx <= '0;
          xr <= '0;
        end else if (xr == RW'(CELL - 1)) begin
          cx <= cx + 8'd1;
          xr <= '0;
        end else begin
          xr <= xr + RW'(1);
        end
      end
    end

    assign cell_c[p] = (xi >= BX) && (xi < BX + BWPX) && (yi >= Y0) && (yi < Y0 + BHPX);
    assign ring_c[p] = !cell_c[p] && (xi + 2 >= BX) && (xi < BX + BWPX + 2) &&
                       (yi + 2 >= Y0) && (yi < Y0 + BHPX + 2);
    assign grid_c[p] = (xr == '0) || (xr == RW'(CELL - 1)) || (yr == '0) || (yr == RW'(CELL - 1));
    assign raddr_c[p*AW +: AW] = AW'(int'(cy) * COLS + int'(cx));
    assign fl_c[p]       = (st == RUN) && ph && (cy == {3'b000, row_q});
    assign flash_busy[p] = (st != IDLE);
    assign flash_done[p] = (st == DONE);

    always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
        st    <= IDLE;
        row_q <= '0;
        fc    <= '0;
        bc    <= '0;
        ph    <= 1'b0;
      end else begin
        st    <= st_n;
        row_q <= row_n;
        fc    <= fc_n;
        bc    <= bc_n;
        ph    <= ph_n;
      end
    end

    // ph tracks (fc / BLINK_FRAMES) & 1 without a divider.
    always_comb begin
      st_n  = st;
      row_n = row_q;
      fc_n  = fc;
      bc_n  = bc;
      ph_n  = ph;
      case (st)
        IDLE: if (flash_go[p]) begin
          st_n  = RUN;
          row_n = flash_row[p*5 +: 5];
          fc_n  = '0;
          bc_n  = '0;
          ph_n  = 1'b0;
        end
        RUN: if (frame_end) begin
          if (fc == FW'(FLASH_FRAMES - 1)) begin
            st_n = DONE;
          end else begin
            fc_n = fc + FW'(1);
            if (bc == BW'(BLINK_FRAMES - 1)) begin
              bc_n = '0;
              ph_n = ~ph;
            end else begin
              bc_n = bc + BW'(1);
            end
          end
        end
        DONE:    st_n = IDLE;
        default: st_n = IDLE;
      endcase
    end
  end

  function automatic logic [11:0] pal(input logic [2:0] c);
    case (c)
      3'd1:    pal = 12'h0FF;
      3'd2:    pal = 12'h00F;
      3'd3:    pal = 12'hFA0;
      3'd4:    pal = 12'hFF0;
      3'd5:    pal = 12'h0F0;
      3'd6:    pal = 12'hA0F;
      3'd7:    pal = 12'hF00;
      default: pal = 12'h000;
    endcase
  endfunction

  // Regions never overlap, so at most one player contributes per pixel.
  always_comb begin
    rgb_c = 12'h000;
    if (act2) begin
      for (int p = 0; p < NUM_P; p++) begin
        if (cell2[p]) begin
          if (fl2[p]) rgb_c = 12'hFFF;
          else if (rdata[p*3 +: 3] != 3'd0) rgb_c = grid2[p] ? 12'h777 : pal(rdata[p*3 +: 3]);
        end else if (ring2[p]) begin
          rgb_c = 12'hFFF;
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      raddr <= '0;
      act1  <= 1'b0;
      cell1 <= '0;
      ring1 <= '0;
      grid1 <= '0;
      fl1   <= '0;
      act2  <= 1'b0;
      cell2 <= '0;
      ring2 <= '0;
      grid2 <= '0;
      fl2   <= '0;
      rgb   <= '0;
    end else begin
      for (int p = 0; p < NUM_P; p++)
        if (cell_c[p]) raddr[p*AW +: AW] <= raddr_c[p*AW +: AW];
      act1  <= adv;
      cell1 <= cell_c;
      ring1 <= ring_c;
      grid1 <= grid_c;
      fl1   <= fl_c;
      act2  <= act1;
      cell2 <= cell1;
      ring2 <= ring1;
      grid2 <= grid1;
      fl2   <= fl1;
      rgb   <= rgb_c;
    end
  end
endmodule

// File: tb/tb_board_grid_renderer.sv
// Randomised scan of a scaled-down 3-player screen against a pixel-level reference model.
module tb_board_grid_renderer;
  localparam int NP = 3, COLS = 5, ROWS = 6, CELL = 4, HA = 96, VA = 36;
  localparam int X0 = 8, Y0 = 6, PITCH = 28, BF = 2, FF = 6, AW = 5;

  logic              pclk = 1'b0, rstn = 1'b0, hen = 1'b0, ven = 1'b0;
  logic [NP*AW-1:0]  raddr;
  logic [NP*3-1:0]   rdata = '0;
  logic [NP-1:0]     flash_go = '0;
  logic [NP*5-1:0]   flash_row = '0;
  logic [NP-1:0]     flash_busy, flash_done;
  logic [11:0]       rgb;

  board_grid_renderer #(
    .NUM_P(NP), .COLS(COLS), .ROWS(ROWS), .CELL(CELL), .H_ACT(HA), .V_ACT(VA),
    .X0(X0), .Y0(Y0), .PITCH(PITCH), .BLINK_FRAMES(BF), .FLASH_FRAMES(FF), .AW(AW)
  ) dut (
    .pclk(pclk), .rstn(rstn), .hen(hen), .ven(ven), .raddr(raddr), .rdata(rdata),
    .flash_go(flash_go), .flash_row(flash_row), .flash_busy(flash_busy),
    .flash_done(flash_done), .rgb(rgb)
  );

  always #5 pclk = ~pclk;

  logic [2:0] mem [NP][COLS*ROWS];
  always @(posedge pclk)
    for (int p = 0; p < NP; p++) rdata[p*3 +: 3] <= mem[p][raddr[p*AW +: AW]];

  int          vectors = 0, miscompares = 0;
  int          mx, my, frames, cyc = 0;
  bit          mbusy [NP];
  int          go_frame [NP], done_cyc [NP], mrow [NP];
  logic [AW-1:0] exp_raddr [NP];
  logic [11:0] expq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [11:0] pal(input int c);
    logic [11:0] t [8] = '{12'h000, 12'h0FF, 12'h00F, 12'hFA0, 12'hFF0, 12'h0F0, 12'hA0F, 12'hF00};
    return t[c];
  endfunction

  function automatic bit in_cell(input int p, input int x, input int y);
    int bx = X0 + p * PITCH;
    return x >= bx && x < bx + COLS*CELL && y >= Y0 && y < Y0 + ROWS*CELL;
  endfunction

  function automatic logic [11:0] model_rgb(input int x, input int y, input bit act);
    logic [11:0] r = 12'h000;
    if (!act) return r;
    for (int p = 0; p < NP; p++) begin
      int bx = X0 + p * PITCH;
      if (in_cell(p, x, y)) begin
        int rx = x - bx, ry = y - Y0;
        int c = int'(mem[p][(ry / CELL) * COLS + rx / CELL]);
        int fc = frames - go_frame[p];
        bit lit = mbusy[p] && cyc != done_cyc[p] && ((fc / BF) % 2) == 1 && (ry / CELL) == mrow[p];
        if (lit) r = 12'hFFF;
        else if (c == 0) r = 12'h000;
        else if (rx % CELL == 0 || rx % CELL == CELL-1 || ry % CELL == 0 || ry % CELL == CELL-1) r = 12'h777;
        else r = pal(c);
      end else if (x + 2 >= bx && x < bx + COLS*CELL + 2 && y + 2 >= Y0 && y < Y0 + ROWS*CELL + 2) begin
        r = 12'hFFF;
      end
    end
    return r;
  endfunction

  // One pixel clock: check outputs, drive inputs, advance the model across the edge.
  task automatic step(input bit h, input bit v, input logic [NP-1:0] go, input logic [NP*5-1:0] rows);
    bit fe;
    bit busy_prev [NP];
    check("rgb", rgb, expq.pop_front());
    for (int p = 0; p < NP; p++) begin
      check($sformatf("busy%0d", p), flash_busy[p], mbusy[p]);
      check($sformatf("done%0d", p), flash_done[p], mbusy[p] && cyc == done_cyc[p]);
      check($sformatf("raddr%0d", p), raddr[p*AW +: AW], exp_raddr[p]);
    end
    hen = h; ven = v; flash_go = go; flash_row = rows;
    expq.push_back(model_rgb(mx, my, h && v));
    for (int p = 0; p < NP; p++)
      if (in_cell(p, mx, my))
        exp_raddr[p] = AW'(((my - Y0) / CELL) * COLS + (mx - X0 - p * PITCH) / CELL);
    @(posedge pclk);
    fe = h && v && mx == HA-1 && my == VA-1;
    busy_prev = mbusy;
    if (h && v) begin
      mx++;
      if (mx == HA) begin mx = 0; my = (my + 1) % VA; end
    end
    if (fe) begin
      frames++;
      for (int p = 0; p < NP; p++)
        if (mbusy[p] && cyc != done_cyc[p] && frames - go_frame[p] == FF) done_cyc[p] = cyc + 1;
    end
    for (int p = 0; p < NP; p++)
      if (mbusy[p] && cyc == done_cyc[p]) mbusy[p] = 0;
    for (int p = 0; p < NP; p++)
      if (go[p] && !busy_prev[p]) begin
        mbusy[p] = 1; go_frame[p] = frames; mrow[p] = int'(rows[p*5 +: 5]); done_cyc[p] = -1;
      end
    cyc++;
    @(negedge pclk);
  endtask

  task automatic do_reset();
    rstn = 1'b0; hen = 1'b0; ven = 1'b0; flash_go = '0;
    #1;
    check("rst_busy", flash_busy, 0);
    check("rst_done", flash_done, 0);
    check("rst_rgb", rgb, 0);
    check("rst_raddr", raddr, 0);
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    rstn = 1'b1;
    mx = 0; my = 0; frames = 0;
    for (int p = 0; p < NP; p++) begin
      mbusy[p] = 0; done_cyc[p] = -1; go_frame[p] = 0; mrow[p] = 0; exp_raddr[p] = '0;
    end
    expq = {12'h000, 12'h000, 12'h000};
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(($urandom % 40) != 0, ($urandom % 80) != 0, '0, '0);
  endtask

  task automatic run_idle(input string tag, input bit all_done);
    int budget = 8 * HA * VA;
    bit seen = 0;
    while ((mbusy[0] || mbusy[1] || mbusy[2]) && budget > 0) begin
      if (all_done && flash_done != '0) begin
        check("done_simul", flash_done, 3'b111);
        seen = 1;
      end
      step(($urandom % 40) != 0, ($urandom % 80) != 0, '0, '0);
      budget--;
    end
    check(tag, flash_busy, 0);
    if (all_done) check("done_seen", seen, 1);
  endtask

  initial begin
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < COLS*ROWS; i++) mem[p][i] = 3'($urandom_range(0, 7));
    mem[0][0] = 3'd3;
    @(negedge pclk);
    do_reset();

    step(1, 1, '0, '0);
    step(1, 1, '0, '0);
    check("x_after_2", 32'(dut.x), 2);
    check("y_after_2", 32'(dut.y), 0);

    run(HA * VA + 300);

    step(1, 1, 3'b001, 15'd2);
    run(HA * VA + 150);
    step(1, 1, 3'b011, (15'd7 << 5) | 15'd3);
    run_idle("busy_after_single", 0);
    run(40);

    step(1, 1, 3'b111, {5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5))});
    run_idle("busy_after_triple", 1);
    run(40);

    step(1, 1, 3'b101, {5'd4, 5'd0, 5'd1});
    run(2 * HA * VA + HA * 10);
    do_reset();
    run(HA * VA + 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
